// File: rtl/pwm_capture.sv
// pwm_capture: receive side of the PWM link. Synchronises an external PWM
// waveform, measures its period and high time in clk cycles, and exposes the
// result through an 8-bit address / 32-bit data register bus.
//
// Registers:
//   0x00 CTRL   (RW) bit0 enable, bit1 clr_ovf (write-1 pulse, reads 0)
//   0x04 STATUS (RO) bit0 valid, bit1 overflow, bit2 running
//   0x08 MEAS   (RO) [31:16] period, [15:0] high
//
// Ports:
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   addr       register byte address
//   wdata      write data
//   wen        write strobe, one cycle per access
//   ren        read strobe, one cycle per access
//   rdata      registered read data, valid the cycle after ren
//   pwm_in     asynchronous PWM input
//   meas_pulse one-cycle pulse in the cycle MEAS is updated
module pwm_capture #(
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        wen,
    input  logic        ren,
    output logic [31:0] rdata,
    input  logic        pwm_in,
    output logic        meas_pulse
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RISE = 2'd1,
        MEAS_HIGH = 2'd2,
        MEAS_LOW  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d_q;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0]       high_q, high_d;
    logic                   enable_q;
    logic                   ovf_q;
    logic                   valid_q;
    logic [31:0]            meas_q;
    logic [31:0]            rdata_q;
    logic [31:0]            rd_mux;

    logic s, rise, fall;
    logic capture, sat;
    logic wr_ctrl, rd_meas;
    logic wdata_unused;

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d_q;
    assign fall = ~s & s_d_q;

    assign wr_ctrl = wen && (addr == 8'h00);
    assign rd_meas = ren && (addr == 8'h08);

    assign wdata_unused = ^wdata[31:2];

    assign rdata      = rdata_q;
    assign meas_pulse = capture;

    // Input synchroniser plus one delay stage for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            s_d_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d_q  <= s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            high_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            high_q  <= high_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        high_d  = high_q;
        capture = 1'b0;
        sat     = 1'b0;
        if (!enable_q) begin
            state_d = IDLE;
            cnt_d   = '0;
            high_d  = '0;
        end else begin
            unique case (state_q)
                IDLE: state_d = WAIT_RISE;
                WAIT_RISE: begin
                    if (rise) begin
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_ONE;
                    end
                end
                MEAS_HIGH: begin
                    if (fall) begin
                        state_d = MEAS_LOW;
                        high_d  = cnt_q;
                        // Hold at the ceiling so the low phase saturates
                        // next cycle instead of wrapping to a short period.
                        cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        sat     = 1'b1;
                        state_d = WAIT_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                MEAS_LOW: begin
                    if (rise) begin
                        capture = 1'b1;
                        state_d = MEAS_HIGH;
                        cnt_d   = CNT_ONE;
                    end else if (cnt_q == CNT_MAX) begin
                        sat     = 1'b1;
                        state_d = WAIT_RISE;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux = '0;
        unique case (addr)
            8'h00:   rd_mux = {31'd0, enable_q};
            8'h04:   rd_mux = {29'd0, (state_q != IDLE), ovf_q, valid_q};
            8'h08:   rd_mux = meas_q;
            default: rd_mux = '0;
        endcase
    end

    // Register file and flags; read data uses pre-write register values
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            enable_q <= 1'b0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
            meas_q   <= '0;
            rdata_q  <= '0;
        end else begin
            if (wr_ctrl) begin
                enable_q <= wdata[0];
            end
            if (sat) begin
                ovf_q <= 1'b1;
            end else if (wr_ctrl && wdata[1]) begin
                ovf_q <= 1'b0;
            end
            if (capture) begin
                valid_q <= 1'b1;
                meas_q  <= {16'(cnt_q), 16'(high_q)};
            end else if (rd_meas) begin
                valid_q <= 1'b0;
            end
            if (ren) begin
                rdata_q <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture (CNT_W=8): PWM loopback measurement, valid
// handshake, stuck-input overflow, enable abort, bus corner cases and reset.
module tb_pwm_capture;

    logic        clk;
    logic        reset_n;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        wen;
    logic        ren;
    logic [31:0] rdata;
    logic        pwm_in;
    logic        meas_pulse;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    // PWM generator controls: mode 0 = held low, 1 = held high, 2 = periodic
    int gen_mode = 2;
    int per = 100;
    int hi = 30;
    int ph = 0;

    pwm_capture #(.CNT_W(8), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .addr       (addr),
        .wdata      (wdata),
        .wen        (wen),
        .ren        (ren),
        .rdata      (rdata),
        .pwm_in     (pwm_in),
        .meas_pulse (meas_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        pwm_in = 1'b0;
        forever begin
            @(negedge clk);
            if (gen_mode == 0) begin
                pwm_in = 1'b0;
            end else if (gen_mode == 1) begin
                pwm_in = 1'b1;
            end else begin
                ph = (ph + 1 >= per) ? 0 : ph + 1;
                pwm_in = (ph < hi);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset_n && meas_pulse) pulse_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        addr  = a;
        wdata = d;
        wen   = 1'b1;
        @(negedge clk);
        wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d);
        @(negedge clk);
        addr = a;
        ren  = 1'b1;
        @(negedge clk);
        ren  = 1'b0;
        d    = rdata;
    endtask

    task automatic wait_pulse(input string tag, input int max_cyc);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < max_cyc && !seen; i++) begin
            @(negedge clk);
            if (meas_pulse) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd1);
    endtask

    task automatic set_gen(input int p, input int h);
        per = p;
        hi  = h;
        ph  = 0;
        gen_mode = 2;
    endtask

    initial begin
        logic [31:0] d;
        int pc;

        reset_n = 1'b0;
        addr    = '0;
        wdata   = '0;
        wen     = 1'b0;
        ren     = 1'b0;
        set_gen(100, 30);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_pulse", {31'd0, meas_pulse}, 32'h0);
        reset_n = 1'b1;
        bus_read(8'h04, d); check("init_status", d, 32'h0);
        bus_read(8'h08, d); check("init_meas", d, 32'h0);
        bus_read(8'h00, d); check("init_ctrl", d, 32'h0);

        // Loopback 100/30
        pc = pulse_cnt;
        bus_write(8'h00, 32'h1);
        wait_pulse("pulse_100_30", 400);
        bus_read(8'h04, d); check("status_valid", d, 32'h5);
        check("pulse_once", pulse_cnt - pc, 32'd1);
        bus_read(8'h08, d); check("meas_100_30", d, 32'h0064_001E);
        bus_read(8'h04, d); check("valid_cleared", d, 32'h4);
        wait_pulse("pulse_again", 300);
        bus_read(8'h04, d); check("valid_back", d, 32'h5);
        bus_read(8'h08, d); check("meas_same", d, 32'h0064_001E);

        // Minimum waveform: high 1, period 2
        bus_write(8'h00, 32'h0);
        set_gen(2, 1);
        repeat (20) @(negedge clk);
        bus_write(8'h00, 32'h1);
        wait_pulse("pulse_2_1", 50);
        bus_read(8'h08, d); check("meas_2_1", d, 32'h0002_0001);

        // Clear enable while in MEAS_LOW
        bus_write(8'h00, 32'h0);
        set_gen(100, 30);
        repeat (20) @(negedge clk);
        bus_write(8'h00, 32'h1);
        wait_pulse("pulse_pre_abort", 300);
        repeat (40) @(negedge clk);
        bus_write(8'h00, 32'h0);
        bus_read(8'h04, d); check("abort_status", d, 32'h1);
        bus_read(8'h08, d); check("abort_meas", d, 32'h0064_001E);
        pc = pulse_cnt;
        repeat (250) @(negedge clk);
        check("idle_no_pulse", pulse_cnt - pc, 32'd0);
        bus_read(8'h08, d); check("idle_meas_kept", d, 32'h0064_001E);

        // Re-enable on a new waveform: first capture must be a full period
        set_gen(80, 20);
        repeat (20) @(negedge clk);
        bus_write(8'h00, 32'h1);
        wait_pulse("pulse_80_20", 400);
        bus_read(8'h08, d); check("meas_80_20", d, 32'h0050_0014);

        // Stuck low -> overflow, valid stays clear
        gen_mode = 0;
        repeat (10) @(negedge clk);
        bus_read(8'h08, d); check("meas_before_stuck", d, 32'h0050_0014);
        pc = pulse_cnt;
        repeat (300) @(negedge clk);
        bus_read(8'h04, d); check("stuck_low_status", d, 32'h6);
        check("stuck_no_pulse", pulse_cnt - pc, 32'd0);
        bus_write(8'h00, 32'h3);
        bus_read(8'h04, d); check("ovf_cleared", d, 32'h4);
        bus_read(8'h00, d); check("ctrl_readback", d, 32'h1);

        // Stuck high -> overflow
        gen_mode = 1;
        repeat (300) @(negedge clk);
        bus_read(8'h04, d); check("stuck_high_status", d, 32'h6);
        bus_write(8'h00, 32'h3);
        bus_read(8'h04, d); check("ovf_cleared2", d, 32'h4);

        // Unmapped address
        bus_read(8'h0C, d); check("read_0c", d, 32'h0);
        bus_write(8'h0C, 32'hFFFF_FFFF);
        bus_read(8'h00, d); check("ctrl_after_0c", d, 32'h1);

        // Simultaneous write and read of CTRL returns pre-write value
        @(negedge clk);
        addr  = 8'h00;
        wdata = 32'h0;
        wen   = 1'b1;
        ren   = 1'b1;
        @(negedge clk);
        wen = 1'b0;
        ren = 1'b0;
        check("rw_same_cycle", rdata, 32'h1);
        bus_read(8'h00, d); check("ctrl_after_rw", d, 32'h0);

        // Reset mid-period
        set_gen(100, 30);
        bus_write(8'h00, 32'h1);
        wait_pulse("pulse_pre_reset", 300);
        repeat (50) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("reset_rdata", rdata, 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reset_pulse", {31'd0, meas_pulse}, 32'h0);
        end
        reset_n = 1'b1;
        bus_read(8'h04, d); check("post_rst_status", d, 32'h0);
        bus_read(8'h08, d); check("post_rst_meas", d, 32'h0);
        bus_read(8'h00, d); check("post_rst_ctrl", d, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
